seq_div_16: RTL and testbench
=============================

# seq_div_16

Sequential unsigned 32÷16 divider: the inverse companion to the 16×16 Dadda multiplier in the arithmetic library. It accepts a 32-bit dividend and a 16-bit divisor over a valid/ready handshake, iterates one quotient bit per clock (two with radix-4 enabled), and returns a 16-bit quotient and 16-bit remainder over a second valid/ready handshake. It is used in normalisation and scaling paths where a full-width combinational divider is too large.

## Interface
- `ERR_QUOT`, default 16'hFFFF: quotient value returned on divide-by-zero or overflow.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands; high only in IDLE.
- `dividend` in 32: unsigned dividend.
- `divisor` in 16: unsigned divisor.
- `out_valid` out 1: result valid; high only in DONE.
- `out_ready` in 1: consumer accepts result.
- `quotient` out 16: unsigned quotient.
- `remainder` out 16: unsigned remainder.
- `div_zero` out 1: divisor was zero.
- `overflow` out 1: quotient does not fit in 16 bits (dividend[31:16] >= divisor); also set when `div_zero` is set.
- `busy` out 1: high in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`, operands are latched and checked:
  - divisor==0 -> DONE; `div_zero`=1, `overflow`=1, `quotient`=ERR_QUOT, `remainder`=dividend[15:0].
  - else if dividend[31:16] >= divisor -> DONE; `overflow`=1, `div_zero`=0, `quotient`=ERR_QUOT, `remainder`=dividend[15:0].
  - else -> CALC; iteration counter loads N-1, where N=16 (8 with radix-4).
- CALC: each cycle performs one restoring-equivalent step per bit. Partial remainder is 17 bits; shift in the next dividend bit, subtract divisor, keep the difference if it is non-negative, and shift the quotient bit in. Non-restoring internals are permitted; the results must be bit-identical to restoring division. After N steps -> DONE.
- Result invariants: `dividend` == `quotient`*`divisor`+`remainder`, and `remainder` < `divisor`.
- DONE: `out_valid`=1; outputs are held stable until `out_valid`&`out_ready`, then -> IDLE.
- `in_valid` outside IDLE is ignored, and the operand inputs are don't-care there.
- `in_ready` and `out_valid` are never high in the same cycle. Throughput is one operation per N+2 cycles minimum.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `quotient`=0, `remainder`=0, `div_zero`=0, `overflow`=0.
- Reset mid-operation: the in-flight operation is discarded. After reset releases, the block is in IDLE and accepts a new operation on the first rising edge.
- Latency: with acceptance at edge E0, `out_valid` is high after edge E16 (E8 with radix-4). Error cases have `out_valid` high after E1.
- The result handshake completes at the edge where `out_valid`&`out_ready`. `in_ready` is high in the following cycle.
- `out_ready` held high in DONE gives exactly one cycle of `out_valid`.
- Result outputs change only on entry to DONE; `quotient` and `remainder` hold their last value in IDLE.

## Configuration
- `SEQ_DIV16_RADIX4_EN` defined: two quotient bits per CALC cycle (two cascaded subtract stages); N=8, normal latency 8 edges.
- Undefined: one bit per cycle; N=16, normal latency 16 edges.
- Results, error behaviour and handshakes are identical in both builds.

## Test plan
- dividend 32'd1000, divisor 16'd7 -> `quotient`=142, `remainder`=6, flags 0; `out_valid` after E16 (E8 radix-4).
- dividend 32'hFFFE_FFFF, divisor 16'hFFFF -> `quotient`=16'hFFFF, `remainder`=16'hFFFE, `overflow`=0.
- dividend 32'h0000_1234, divisor 0 -> after E1: `div_zero`=1, `overflow`=1, `quotient`=16'hFFFF, `remainder`=16'h1234.
- dividend 32'h0005_0000, divisor 16'd5 -> `overflow`=1, `div_zero`=0, `quotient`=16'hFFFF, `remainder`=0.
- `out_ready` held low 5 cycles in DONE while a second `in_valid` is driven -> outputs stable, `in_ready`=0, second operand not taken; after the handshake, `in_ready`=1 next cycle.
- `rst` pulsed after 8 CALC cycles -> `out_valid`=0 and `busy`=0 immediately (asynchronous). Then 32'd65535 / 16'd256 -> `quotient`=255, `remainder`=255.

Source files
------------

// File: rtl/seq_div_16.sv
// seq_div_16 -- sequential unsigned 32/16 divider (restoring algorithm).
//
// Operands are taken over an in_valid/in_ready handshake. One quotient bit
// is produced per CALC cycle, or two with SEQ_DIV16_RADIX4_EN defined. The
// result is returned over an out_valid/out_ready handshake.
//
// Build option:
//   SEQ_DIV16_RADIX4_EN  defined   : two quotient bits per cycle, 8 CALC cycles
//                        undefined : one quotient bit per cycle, 16 CALC cycles
//
// Parameters:
//   ERR_QUOT   quotient returned on divide-by-zero or quotient overflow
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid, in_ready     operand handshake (in_ready high only in IDLE)
//   dividend[31:0]         unsigned dividend
//   divisor[15:0]          unsigned divisor
//   out_valid, out_ready   result handshake (out_valid high only in DONE)
//   quotient[15:0]         unsigned quotient
//   remainder[15:0]        unsigned remainder
//   div_zero               divisor was zero
//   overflow               quotient does not fit in 16 bits (or div_zero)
//   busy                   iteration in progress (CALC)
module seq_div_16 #(
  parameter logic [15:0] ERR_QUOT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero,
  output logic        overflow,
  output logic        busy
);

`ifdef SEQ_DIV16_RADIX4_EN
  localparam logic [3:0] CNT_LOAD = 4'd7;
`else
  localparam logic [3:0] CNT_LOAD = 4'd15;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        err_pend;   // operands rejected: report ERR_QUOT
  logic        dz_pend;    // rejected because divisor was zero

  // Working datapath: partial remainder, dividend/quotient shift register, divisor.
  logic [15:0] pr;
  logic [15:0] lo;
  logic [15:0] dvs;
  logic [15:0] pr_step;
  logic [15:0] lo_step;
  logic [16:0] s1;

  // One restoring step. The shifted value is 17 bits wide, but after a
  // successful subtract the difference is below the divisor, so the low
  // 16 bits of the modular difference are exact.
  // Returns {quotient_bit, new_partial_remainder}.
  function automatic logic [16:0] div_step(input logic [15:0] pr_in,
                                           input logic        bit_in,
                                           input logic [15:0] d);
    logic [16:0] sh;
    logic [15:0] diff;
    sh   = {pr_in, bit_in};
    diff = sh[15:0] - d;
    if (sh >= {1'b0, d}) return {1'b1, diff};
    else                 return {1'b0, sh[15:0]};
  endfunction

  // Dividend bits leave lo at the MSB while quotient bits enter at the LSB,
  // so lo holds the full quotient after the last step.
`ifdef SEQ_DIV16_RADIX4_EN
  logic [16:0] s2;
  always_comb begin
    s1      = div_step(pr, lo[15], dvs);
    s2      = div_step(s1[15:0], lo[14], dvs);
    pr_step = s2[15:0];
    lo_step = {lo[13:0], s1[16], s2[16]};
  end
`else
  always_comb begin
    s1      = div_step(pr, lo[15], dvs);
    pr_step = s1[15:0];
    lo_step = {lo[14:0], s1[16]};
  end
`endif

  // Next state and handshake outputs. Rejected operands still spend one
  // cycle in CALC (counter loaded with zero) so the error result appears
  // one edge after acceptance.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      err_pend  <= 1'b0;
      dz_pend   <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 16'd0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && in_valid) begin
        // divisor==0 also satisfies the high-half comparison.
        err_pend <= (dividend[31:16] >= divisor);
        dz_pend  <= (divisor == 16'd0);
        cnt      <= (dividend[31:16] >= divisor) ? 4'd0 : CNT_LOAD;
      end else if (state == S_CALC) begin
        if (cnt == 4'd0) begin
          // lo still holds dividend[15:0] here on the error path.
          quotient  <= err_pend ? ERR_QUOT : lo_step;
          remainder <= err_pend ? lo       : pr_step;
          div_zero  <= dz_pend;
          overflow  <= err_pend;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Datapath registers: no reset needed, always loaded before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      pr  <= dividend[31:16];
      lo  <= dividend[15:0];
      dvs <= divisor;
    end else if (state == S_CALC) begin
      pr <= pr_step;
      lo <= lo_step;
    end
  end

endmodule

// File: tb/tb_seq_div_16.sv
module tb_seq_div_16;

`ifdef SEQ_DIV16_RADIX4_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  seq_div_16 #(.ERR_QUOT(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then count edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, output int n);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Complete the result handshake; called at a negedge.
  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ovalid_after_ack"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_iready_after_ack"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'd0;
    divisor   = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_quotient",  {16'd0, quotient},  32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_flags",     {30'd0, div_zero, overflow}, 32'd0);
    rst = 1'b0;

    // 1000 / 7
    run_op(32'd1000, 16'd7, lat);
    chk("t1_latency",  lat, LAT);
    chk("t1_quotient", {16'd0, quotient},  32'd142);
    chk("t1_remainder",{16'd0, remainder}, 32'd6);
    chk("t1_flags",    {30'd0, div_zero, overflow}, 32'd0);
    chk("t1_no_iready",{31'd0, in_ready}, 32'd0);
    ack("t1");

    // Largest non-overflowing quotient, 17-bit partial remainder path.
    run_op(32'hFFFE_FFFF, 16'hFFFF, lat);
    chk("t2_latency",  lat, LAT);
    chk("t2_quotient", {16'd0, quotient},  32'h0000_FFFF);
    chk("t2_remainder",{16'd0, remainder}, 32'h0000_FFFE);
    chk("t2_flags",    {30'd0, div_zero, overflow}, 32'd0);
    ack("t2");

    // Divide by zero
    run_op(32'h0000_1234, 16'd0, lat);
    chk("t3_latency",  lat, 1);
    chk("t3_quotient", {16'd0, quotient},  32'h0000_FFFF);
    chk("t3_remainder",{16'd0, remainder}, 32'h0000_1234);
    chk("t3_flags",    {30'd0, div_zero, overflow}, 32'd3);
    ack("t3");

    // Quotient overflow at the boundary dividend[31:16] == divisor
    run_op(32'h0005_0000, 16'd5, lat);
    chk("t4_latency",  lat, 1);
    chk("t4_quotient", {16'd0, quotient},  32'h0000_FFFF);
    chk("t4_remainder",{16'd0, remainder}, 32'd0);
    chk("t4_flags",    {30'd0, div_zero, overflow}, 32'd1);
    ack("t4");

    // Just below the overflow boundary
    run_op(32'h7FFF_FFFF, 16'h8000, lat);
    chk("t5_latency",  lat, LAT);
    chk("t5_quotient", {16'd0, quotient},  32'h0000_FFFF);
    chk("t5_remainder",{16'd0, remainder}, 32'h0000_7FFF);
    chk("t5_flags",    {30'd0, div_zero, overflow}, 32'd0);
    ack("t5");

    // Back-pressure: out_ready low for 5 cycles while new operands are offered
    run_op(32'd100000, 16'd300, lat);
    chk("t6_latency", lat, LAT);
    dividend = 32'd77;
    divisor  = 16'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_hold_ovalid",   {31'd0, out_valid}, 32'd1);
      chk("t6_hold_iready",   {31'd0, in_ready},  32'd0);
      chk("t6_hold_quotient", {16'd0, quotient},  32'd333);
      chk("t6_hold_remainder",{16'd0, remainder}, 32'd100);
      chk("t6_hold_flags",    {30'd0, div_zero, overflow}, 32'd0);
    end
    in_valid = 1'b0;
    ack("t6");
    @(posedge clk);
    @(negedge clk);
    chk("t6_not_taken_busy",   {31'd0, busy},      32'd0);
    chk("t6_not_taken_iready", {31'd0, in_ready},  32'd1);
    chk("t6_idle_quotient",    {16'd0, quotient},  32'd333);
    chk("t6_idle_remainder",   {16'd0, remainder}, 32'd100);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (LAT / 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_ovalid",   {31'd0, out_valid}, 32'd0);
    chk("t7_rst_busy",     {31'd0, busy},      32'd0);
    chk("t7_rst_iready",   {31'd0, in_ready},  32'd1);
    chk("t7_rst_quotient", {16'd0, quotient},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd65535, 16'd256, lat);
    chk("t7_latency",  lat, LAT);
    chk("t7_quotient", {16'd0, quotient},  32'd255);
    chk("t7_remainder",{16'd0, remainder}, 32'd255);
    chk("t7_flags",    {30'd0, div_zero, overflow}, 32'd0);
    ack("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
